writeback_trace_capture: RTL and testbench

//   Reader/consumer side of the processor's ProgramCounter/WriteData debug outputs.

---
 rtl/writeback_trace_capture.sv | 148 ++++++++++++++
 tb/tb_writeback_trace_capture.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/writeback_trace_capture.sv
// Captures one (PC, WriteData) entry per retired instruction into a circular FIFO
// drained through a request/valid port, and flags a halt when the PC stops moving.
module writeback_trace_capture #(
    parameter int ADDR_W      = 3,
    parameter int HALT_CYCLES = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [31:0]       ProgramCounter,
    input  logic [31:0]       WriteData,
    input  logic              RdReq,
    output logic              RdValid,
    output logic [31:0]       RdPC,
    output logic [31:0]       RdData,
    output logic [ADDR_W:0]   Count,
    output logic              Empty,
    output logic              Full,
    output logic              Overflow,
    output logic              HaltDetected
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SCW   = $clog2(HALT_CYCLES);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO  = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [SCW-1:0]    STABLE_ONE  = SCW'(1);
    localparam logic [SCW-1:0]    STABLE_LAST = SCW'(HALT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state_r, stateNext_s;
    logic [31:0]       prevPc_r, prevPcNext_s;
    logic [SCW-1:0]    stableCnt_r, stableNext_s;
    logic              capture_s, haltSet_s;
    logic              popAcc_s, capAcc_s, drop_s;
    logic [ADDR_W-1:0] wrPtr_r, rdPtr_r;
    logic [ADDR_W:0]   countNext_s;
    logic [63:0]       mem_r [DEPTH];

    // Next-state decode: capture on a new PC, count repeats of the same PC toward a halt
    always_comb begin
        stateNext_s  = state_r;
        prevPcNext_s = prevPc_r;
        stableNext_s = stableCnt_r;
        capture_s    = 1'b0;
        haltSet_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (Enable) begin
                    capture_s    = 1'b1;
                    prevPcNext_s = ProgramCounter;
                    stableNext_s = {SCW{1'b0}};
                    stateNext_s  = RUN;
                end else begin
                    stateNext_s  = IDLE;
                end
            end
            RUN: begin
                if (Enable) begin
                    if (ProgramCounter != prevPc_r) begin
                        capture_s    = 1'b1;
                        prevPcNext_s = ProgramCounter;
                        stableNext_s = {SCW{1'b0}};
                    end else if (stableCnt_r == STABLE_LAST) begin
                        stableNext_s = stableCnt_r + STABLE_ONE;
                        haltSet_s    = 1'b1;
                        stateNext_s  = HALTED;
                    end else begin
                        stableNext_s = stableCnt_r + STABLE_ONE;
                    end
                end else begin
                    stateNext_s = RUN;
                end
            end
            HALTED:  stateNext_s = HALTED;
            default: stateNext_s = IDLE;
        endcase
    end

    // A full FIFO still accepts a capture when the same cycle pops; an empty one never bypasses
    assign popAcc_s = RdReq && (Count != CNT_ZERO);
    assign capAcc_s = capture_s && ((Count != CNT_DEPTH) || popAcc_s);
    assign drop_s   = capture_s && (Count == CNT_DEPTH) && !popAcc_s;

    // Occupancy update from the accepted capture/pop pair
    always_comb begin
        case ({capAcc_s, popAcc_s})
            2'b10:   countNext_s = Count + CNT_ONE;
            2'b01:   countNext_s = Count - CNT_ONE;
            default: countNext_s = Count;
        endcase
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge Clock) begin
        if (capAcc_s) begin
            mem_r[wrPtr_r] <= {ProgramCounter, WriteData};
        end
    end

    // Control state, pointers and registered read-port outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r      <= IDLE;
            prevPc_r     <= 32'd0;
            stableCnt_r  <= {SCW{1'b0}};
            wrPtr_r      <= {ADDR_W{1'b0}};
            rdPtr_r      <= {ADDR_W{1'b0}};
            Count        <= CNT_ZERO;
            Empty        <= 1'b1;
            Full         <= 1'b0;
            RdValid      <= 1'b0;
            RdPC         <= 32'd0;
            RdData       <= 32'd0;
            Overflow     <= 1'b0;
            HaltDetected <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            prevPc_r    <= prevPcNext_s;
            stableCnt_r <= stableNext_s;
            Count       <= countNext_s;
            Empty       <= (countNext_s == CNT_ZERO);
            Full        <= (countNext_s == CNT_DEPTH);
            RdValid     <= popAcc_s;
            if (capAcc_s) begin
                wrPtr_r <= wrPtr_r + PTR_ONE;
            end
            if (popAcc_s) begin
                rdPtr_r        <= rdPtr_r + PTR_ONE;
                {RdPC, RdData} <= mem_r[rdPtr_r];
            end
            if (drop_s) begin
                Overflow <= 1'b1;
            end
            if (haltSet_s) begin
                HaltDetected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_trace_capture.sv
// Bench for writeback_trace_capture: directed scenarios followed by random traffic,
// every cycle compared against a queue-based trace model.
module tb_writeback_trace_capture;

    localparam int ADDR_W      = 3;
    localparam int DEPTH       = 8;
    localparam int HALT_CYCLES = 8;

    logic              Clock = 1'b0;
    logic              Reset, Enable, RdReq;
    logic [31:0]       ProgramCounter, WriteData;
    logic              RdValid, Empty, Full, Overflow, HaltDetected;
    logic [31:0]       RdPC, RdData;
    logic [ADDR_W:0]   Count;

    writeback_trace_capture #(.ADDR_W(ADDR_W), .HALT_CYCLES(HALT_CYCLES)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable),
        .ProgramCounter(ProgramCounter), .WriteData(WriteData), .RdReq(RdReq),
        .RdValid(RdValid), .RdPC(RdPC), .RdData(RdData), .Count(Count),
        .Empty(Empty), .Full(Full), .Overflow(Overflow), .HaltDetected(HaltDetected)
    );

    always #5 Clock = ~Clock;

    int compared   = 0;
    int mismatched = 0;

    // Trace model: what the capture should hold, described per instruction
    typedef struct {
        logic [31:0] pc;
        logic [31:0] wd;
    } entry_t;
    entry_t      q[$];
    bit          mOv, mHalt, mHavePrev, mRv;
    logic [31:0] mPrev, mRdPc, mRdData;
    int          mRun;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        bit     pop, cap;
        entry_t e;
        if (Reset) begin
            q.delete();
            mOv = 1'b0; mHalt = 1'b0; mHavePrev = 1'b0; mRv = 1'b0;
            mPrev = 32'd0; mRdPc = 32'd0; mRdData = 32'd0; mRun = 0;
        end else begin
            pop = RdReq && (q.size() > 0);
            cap = 1'b0;
            if (Enable && !mHalt) begin
                if (!mHavePrev || ProgramCounter != mPrev) begin
                    cap = 1'b1;
                    mPrev = ProgramCounter;
                    mHavePrev = 1'b1;
                    mRun = 1;
                end else begin
                    mRun++;
                    if (mRun >= HALT_CYCLES) mHalt = 1'b1;
                end
            end
            mRv = pop;
            if (pop) begin
                e = q.pop_front();
                mRdPc = e.pc;
                mRdData = e.wd;
            end
            if (cap) begin
                if (q.size() < DEPTH) begin
                    e.pc = ProgramCounter;
                    e.wd = WriteData;
                    q.push_back(e);
                end else begin
                    mOv = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input logic [31:0] pc,
                       input logic [31:0] wd, input bit rd);
        Reset = rst; Enable = en; ProgramCounter = pc; WriteData = wd; RdReq = rd;
        @(posedge Clock);
        modelStep();
        #1;
        check("Count",        64'(Count),        64'(q.size()));
        check("Empty",        64'(Empty),        64'(q.size() == 0));
        check("Full",         64'(Full),         64'(q.size() == DEPTH));
        check("Overflow",     64'(Overflow),     64'(mOv));
        check("HaltDetected", 64'(HaltDetected), 64'(mHalt));
        check("RdValid",      64'(RdValid),      64'(mRv));
        check("RdPC",         64'(RdPC),         64'(mRdPc));
        check("RdData",       64'(RdData),       64'(mRdData));
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        logic [31:0] pc;

        // 1: three captures, three pops
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'd0, 32'd11, 1'b0);
        cyc(1'b0, 1'b1, 32'd4, 32'd22, 1'b0);
        cyc(1'b0, 1'b1, 32'd8, 32'd33, 1'b0);
        check("t1_count3", 64'(Count), 64'd3);
        drain(3);
        check("t1_last_pc", 64'(RdPC), 64'd8);
        check("t1_last_wd", 64'(RdData), 64'd33);

        // 2: nine distinct PCs overflow a depth-8 FIFO
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 1'b0);
        check("t2_overflow", 64'(Overflow), 64'd1);
        drain(9);

        // 3: full FIFO, simultaneous capture and pop
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0);
        cyc(1'b0, 1'b1, 32'h300, 32'hABCD, 1'b1);
        check("t3_count8", 64'(Count), 64'd8);
        drain(8);
        check("t3_last_pc", 64'(RdPC), 64'h300);

        // 4: PC held for HALT_CYCLES samples, then later changes ignored
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h10, $urandom, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h20, $urandom, 1'b0);
        check("t4_halt", 64'(HaltDetected), 64'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h40 + 32'(4 * i), $urandom, 1'b0);
        drain(3);

        // 5: reads on an empty FIFO, then capture + read together
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cyc(1'b0, 1'b1, 32'h44, 32'h55, 1'b1);
        check("t5_count1", 64'(Count), 64'd1);

        // 6: reset while holding entries and halted; same PC recaptured afterwards
        cyc(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 32'h600, $urandom, 1'b0);
        check("t6_count5", 64'(Count), 64'd5);
        cyc(1'b1, 1'b1, 32'h600, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'h600, 32'h77, 1'b0);
        check("t6_recapture", 64'(Count), 64'd1);

        // Random traffic with frequent PC repeats so halts and overflows occur
        pc = 32'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 35) pc = 32'($urandom_range(0, 15)) << 2;
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, pc, $urandom,
                $urandom_range(0, 99) < 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
